spi_slave_word: RTL and testbench

//   Parametrised SPI slave for the shield FPGA; replaces the fixed 8-bit, mode-0 byte slave.

---
 rtl/spi_slave_word.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_slave_word.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// SPI slave with configurable word width and SPI mode, oversampled in the clk_i domain.
// Optional sticky error flags are built when SPIS_ERR_FLAGS_EN is defined.
`timescale 1ns/1ps

module spi_slave_word #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              spi_sck_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              underrun_o
);

  localparam int               CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             SCK_IDLE   = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic             LOAD_AT_CS = (CPHA == 0) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // An empty transmit slot is filled with all ones so the master sees an idle line.
  function automatic logic [DATA_W-1:0] tx_word(input logic valid, input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] word;
    if (valid) begin
      word = data;
    end else begin
      word = {DATA_W{1'b1}};
    end
    return word;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_prev_r;
  logic                   cs_prev_r;

  logic                   sck_now_s;
  logic                   cs_now_s;
  logic                   mosi_now_s;
  logic                   sck_rise_s;
  logic                   sck_fall_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   sample_edge_s;
  logic                   shift_edge_s;
  logic                   active_s;
  logic                   do_sample_s;
  logic                   do_shift_s;
  logic                   load_pt_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_W-1:0]      rx_shift_r;
  logic [DATA_W-1:0]      tx_shift_r;
  logic                   word_done_r;
  logic [DATA_W-1:0]      rx_data_r;
  logic                   rx_valid_r;
  logic                   tx_ready_r;
  logic                   busy_r;
  logic                   miso_oe_r;

  // Synchronisers reset to the inactive bus levels so release from reset creates no edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_r  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_prev_r  <= SCK_IDLE;
      cs_prev_r   <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_now_s  = sck_sync_r[SYNC_STAGES-1];
  assign cs_now_s   = cs_sync_r[SYNC_STAGES-1];
  assign mosi_now_s = mosi_sync_r[SYNC_STAGES-1];

  // Map raw SCK edges onto sample/shift edges for the configured mode.
  always_comb begin
    sck_rise_s    = sck_now_s & ~sck_prev_r;
    sck_fall_s    = ~sck_now_s & sck_prev_r;
    cs_fall_s     = ~cs_now_s & cs_prev_r;
    cs_rise_s     = cs_now_s & ~cs_prev_r;
    sample_edge_s = 1'b0;
    shift_edge_s  = 1'b0;
    if (LOAD_AT_CS == (SCK_IDLE == 1'b0)) begin
      sample_edge_s = sck_rise_s;
      shift_edge_s  = sck_fall_s;
    end else begin
      sample_edge_s = sck_fall_s;
      shift_edge_s  = sck_rise_s;
    end
  end

  // CS rise has priority over any SCK activity in the same cycle.
  always_comb begin
    active_s    = (state_r == ST_ACTIVE);
    do_sample_s = active_s & ~cs_rise_s & sample_edge_s;
    do_shift_s  = active_s & ~cs_rise_s & shift_edge_s;
    load_pt_s   = (~active_s & cs_fall_s & LOAD_AT_CS) |
                  (do_shift_s & (bit_cnt_r == CNT_ZERO));
  end

  // Frame FSM with shift registers, bit counter and rx/tx handshakes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= CNT_ZERO;
      rx_shift_r  <= {DATA_W{1'b0}};
      tx_shift_r  <= {DATA_W{1'b0}};
      word_done_r <= 1'b0;
      rx_data_r   <= {DATA_W{1'b0}};
      rx_valid_r  <= 1'b0;
      tx_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
    end else begin
      tx_ready_r  <= load_pt_s & tx_valid_i;
      word_done_r <= do_sample_s & (bit_cnt_r == CNT_LAST);

      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r    <= ST_ACTIVE;
            busy_r     <= 1'b1;
            miso_oe_r  <= 1'b1;
            bit_cnt_r  <= CNT_ZERO;
            rx_shift_r <= {DATA_W{1'b0}};
            if (load_pt_s) begin
              tx_shift_r <= tx_word(tx_valid_i, tx_data_i);
            end
          end
        end
        ST_ACTIVE: begin
          if (cs_rise_s) begin
            // Abort: partial word dropped, loaded tx word is not kept for the next frame.
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
            bit_cnt_r  <= CNT_ZERO;
            rx_shift_r <= {DATA_W{1'b0}};
            tx_shift_r <= {DATA_W{1'b0}};
          end else begin
            if (do_sample_s) begin
              rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_now_s};
              if (bit_cnt_r == CNT_LAST) begin
                bit_cnt_r <= CNT_ZERO;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
              end
            end
            if (load_pt_s) begin
              tx_shift_r <= tx_word(tx_valid_i, tx_data_i);
            end else if (do_shift_s) begin
              tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          miso_oe_r  <= 1'b0;
          bit_cnt_r  <= CNT_ZERO;
          tx_shift_r <= {DATA_W{1'b0}};
        end
      endcase

      if (word_done_r) begin
        rx_data_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && rx_ready_i) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign spi_miso_o    = tx_shift_r[DATA_W-1];
  assign spi_miso_oe_o = miso_oe_r;
  assign tx_ready_o    = tx_ready_r;
  assign rx_data_o     = rx_data_r;
  assign rx_valid_o    = rx_valid_r;
  assign busy_o        = busy_r;

`ifdef SPIS_ERR_FLAGS_EN
  logic overrun_r;
  logic underrun_r;

  // Sticky error flags; a new frame start clears them unless an event fires that cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      overrun_r  <= (word_done_r & rx_valid_r & ~rx_ready_i) | (overrun_r & ~cs_fall_s);
      underrun_r <= (load_pt_s & ~tx_valid_i) | (underrun_r & ~cs_fall_s);
    end
  end

  assign overrun_o  = overrun_r;
  assign underrun_o = underrun_r;
`else
  assign overrun_o  = 1'b0;
  assign underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word: a mode-0 8-bit instance and a mode-3 16-bit instance.
`timescale 1ns/1ps

module tb_spi_slave_word;

  localparam int HALF = 80;
`ifdef SPIS_ERR_FLAGS_EN
  localparam logic FLAG_BUILD = 1'b1;
`else
  localparam logic FLAG_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sck0, cs0, mosi0, miso0, oe0, txv0, txr0, rxv0, rxr0, busy0, ovr0, unr0;
  logic [7:0] txd0, rxd0;
  logic        sck3, cs3, mosi3, miso3, oe3, txv3, txr3, rxv3, rxr3, busy3, ovr3, unr3;
  logic [15:0] txd3, rxd3;

  spi_slave_word #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
    .clk_i(clk), .rst_n_i(rst_n), .spi_sck_i(sck0), .spi_cs_i(cs0), .spi_mosi_i(mosi0),
    .spi_miso_o(miso0), .spi_miso_oe_o(oe0), .tx_data_i(txd0), .tx_valid_i(txv0),
    .tx_ready_o(txr0), .rx_data_o(rxd0), .rx_valid_o(rxv0), .rx_ready_i(rxr0),
    .busy_o(busy0), .overrun_o(ovr0), .underrun_o(unr0)
  );

  spi_slave_word #(.DATA_W(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
    .clk_i(clk), .rst_n_i(rst_n), .spi_sck_i(sck3), .spi_cs_i(cs3), .spi_mosi_i(mosi3),
    .spi_miso_o(miso3), .spi_miso_oe_o(oe3), .tx_data_i(txd3), .tx_valid_i(txv3),
    .tx_ready_o(txr3), .rx_data_o(rxd3), .rx_valid_o(rxv3), .rx_ready_i(rxr3),
    .busy_o(busy3), .overrun_o(ovr3), .underrun_o(unr3)
  );

  int n_run  = 0;
  int n_fail = 0;
  int pulses0 = 0;
  int pulses3 = 0;
  logic [15:0] rx3_log[$];

  always @(posedge clk) begin
    if (txr0) pulses0 <= pulses0 + 1;
    if (txr3) pulses3 <= pulses3 + 1;
    if (rxv3 && rxr3) rx3_log.push_back(rxd3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mode-0 master: one word (or nbits of it); glue withdraws tx_valid after the frame-start load.
  task automatic m0_frame(input logic [7:0] txw, input logic txv, input logic [7:0] mw,
                          input int nbits, input logic end_cs, output logic [7:0] got);
    got  = 8'h00;
    txd0 = txw;
    txv0 = txv;
    cs0  = 1'b0;
    #(HALF);
    txv0 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi0 = mw[7-i];
      #(HALF);
      got  = {got[6:0], miso0};
      sck0 = 1'b1;
      #(HALF);
      sck0 = 1'b0;
    end
    if (end_cs) begin
      #(HALF);
      cs0 = 1'b1;
      #(2*HALF);
    end
  endtask

  // Mode-3 master: two back-to-back 16-bit words in one CS frame with no SCK gap.
  task automatic m3_frame(input logic [15:0] tw0, input logic [15:0] tw1,
                          input logic [15:0] mw0, input logic [15:0] mw1,
                          output logic [15:0] got0, output logic [15:0] got1);
    logic [15:0] mw;
    logic [15:0] got;
    got0 = 16'h0000;
    got1 = 16'h0000;
    txd3 = tw0;
    txv3 = 1'b1;
    cs3  = 1'b0;
    #(HALF);
    for (int w = 0; w < 2; w++) begin
      mw  = (w == 0) ? mw0 : mw1;
      got = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        sck3  = 1'b0;
        mosi3 = mw[15-i];
        #(HALF);
        got  = {got[14:0], miso3};
        sck3 = 1'b1;
        if (i == 0) begin
          if (w == 0) txd3 = tw1;
          else        txv3 = 1'b0;
        end
        #(HALF);
      end
      if (w == 0) got0 = got;
      else        got1 = got;
    end
    #(HALF);
    cs3 = 1'b1;
    #(2*HALF);
  endtask

  task automatic accept0();
    @(negedge clk);
    rxr0 = 1'b1;
    @(negedge clk);
    rxr0 = 1'b0;
    check("m0 rx_valid cleared after accept", 32'(rxv0), 32'd0);
  endtask

  task automatic check_m0_zero(input string tag);
    check({tag, " miso"},     32'(miso0), 32'd0);
    check({tag, " miso_oe"},  32'(oe0),   32'd0);
    check({tag, " tx_ready"}, 32'(txr0),  32'd0);
    check({tag, " rx_data"},  32'(rxd0),  32'd0);
    check({tag, " rx_valid"}, 32'(rxv0),  32'd0);
    check({tag, " busy"},     32'(busy0), 32'd0);
    check({tag, " overrun"},  32'(ovr0),  32'd0);
    check({tag, " underrun"}, 32'(unr0),  32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       txv;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0]  got;
    logic [15:0] g0, g1;
    int          p;

    vecs[0] = '{tx: 8'hA5, txv: 1'b1, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_pulses: 1};
    vecs[1] = '{tx: 8'h12, txv: 1'b0, mosi: 8'h5A, exp_miso: 8'hFF, exp_rx: 8'h5A, exp_pulses: 0};
    vecs[2] = '{tx: 8'h00, txv: 1'b1, mosi: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF, exp_pulses: 1};
    vecs[3] = '{tx: 8'h81, txv: 1'b1, mosi: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E, exp_pulses: 1};

    rst_n = 1'b0;
    sck0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; txd0 = 8'h00; txv0 = 1'b0; rxr0 = 1'b0;
    sck3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0; txd3 = 16'h0000; txv3 = 1'b0; rxr3 = 1'b1;
    repeat (3) @(negedge clk);
    check_m0_zero("reset m0");
    check("reset m3 busy", 32'(busy3), 32'd0);
    check("reset m3 miso", 32'(miso3), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      p = pulses0;
      m0_frame(vecs[i].tx, vecs[i].txv, vecs[i].mosi, 8, 1'b1, got);
      check("m0 miso word",     32'(got),         32'(vecs[i].exp_miso));
      check("m0 rx_data",       32'(rxd0),        32'(vecs[i].exp_rx));
      check("m0 rx_valid",      32'(rxv0),        32'd1);
      check("m0 tx_ready count", 32'(pulses0 - p), 32'(vecs[i].exp_pulses));
      check("m0 busy idle",     32'(busy0),       32'd0);
      check("m0 miso_oe idle",  32'(oe0),         32'd0);
      check("m0 miso idle",     32'(miso0),       32'd0);
      check("m0 underrun",      32'(unr0),        32'(FLAG_BUILD));
      check("m0 overrun",       32'(ovr0),        32'd0);
      accept0();
    end

    // Two words without accepting: second overwrites, overrun raised.
    m0_frame(8'h11, 1'b1, 8'hC3, 8, 1'b1, got);
    check("ovr first rx_data", 32'(rxd0), 32'h0000_00C3);
    check("ovr first flag",    32'(ovr0), 32'd0);
    m0_frame(8'h22, 1'b1, 8'h96, 8, 1'b1, got);
    check("ovr second rx_data", 32'(rxd0), 32'h0000_0096);
    check("ovr rx_valid held",  32'(rxv0), 32'd1);
    check("ovr flag",           32'(ovr0), 32'(FLAG_BUILD));
    accept0();
    check("ovr flag sticky",    32'(ovr0), 32'(FLAG_BUILD));

    // CS rises after 5 of 8 bits: nothing delivered, counter restarts.
    m0_frame(8'h55, 1'b1, 8'hF0, 5, 1'b1, got);
    check("abort no rx_valid",  32'(rxv0), 32'd0);
    check("abort rx_data kept", 32'(rxd0), 32'h0000_0096);
    check("abort ovr cleared",  32'(ovr0), 32'd0);
    m0_frame(8'h55, 1'b1, 8'h81, 8, 1'b1, got);
    check("after abort rx_data",  32'(rxd0), 32'h0000_0081);
    check("after abort rx_valid", 32'(rxv0), 32'd1);
    check("after abort miso",     32'(got),  32'h0000_0055);
    accept0();

    // Mode 3, 16-bit, two gap-free words in one frame.
    p = pulses3;
    m3_frame(16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678, g0, g1);
    check("m3 miso word0", 32'(g0), 32'h0000_BEEF);
    check("m3 miso word1", 32'(g1), 32'h0000_CAFE);
    check("m3 rx count",   32'(rx3_log.size()), 32'd2);
    check("m3 rx word0",   (rx3_log.size() > 0) ? 32'(rx3_log[0]) : 32'hDEAD_DEAD, 32'h0000_1234);
    check("m3 rx word1",   (rx3_log.size() > 1) ? 32'(rx3_log[1]) : 32'hDEAD_DEAD, 32'h0000_5678);
    check("m3 tx_ready count", 32'(pulses3 - p), 32'd2);
    check("m3 busy idle",  32'(busy3), 32'd0);
    check("m3 underrun",   32'(unr3),  32'd0);

    // Reset mid-frame, then a fresh frame.
    m0_frame(8'hA5, 1'b1, 8'hE7, 3, 1'b0, got);
    check("midframe busy",    32'(busy0), 32'd1);
    check("midframe miso_oe", 32'(oe0),   32'd1);
    rst_n = 1'b0;
    #1;
    check_m0_zero("midframe reset");
    cs0 = 1'b1; sck0 = 1'b0; mosi0 = 1'b0;
    #(HALF);
    rst_n = 1'b1;
    #(HALF);
    p = pulses0;
    m0_frame(8'hA5, 1'b1, 8'h3C, 8, 1'b1, got);
    check("post reset miso",     32'(got),          32'h0000_00A5);
    check("post reset rx_data",  32'(rxd0),         32'h0000_003C);
    check("post reset rx_valid", 32'(rxv0),         32'd1);
    check("post reset tx_ready", 32'(pulses0 - p),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
